// File: rtl/signal_debounce_ctrl_if.sv
// Event/control bundle between the signal debouncer and its environment.
// The master side drives the raw input and controls; the slave side is
// the debouncer itself.
interface signal_debounce_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             signal;
    logic             enable;
    logic             clear;
    logic             evt_ready;
    logic             evt_valid;
    logic             evt_rise;
    logic             level;
    logic [CNT_W-1:0] edge_count;
    logic             overflow;

    modport master (
        output signal, enable, clear, evt_ready,
        input  evt_valid, evt_rise, level, edge_count, overflow
    );

    modport slave (
        input  signal, enable, clear, evt_ready,
        output evt_valid, evt_rise, level, edge_count, overflow
    );
endinterface

// File: rtl/signal_debounce_ctrl.sv
// Debounce controller for one asynchronous input: two-flop synchroniser,
// stability-check FSM, one-entry rise/fall event buffer and an edge counter.
module signal_debounce_ctrl #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    signal_debounce_ctrl_if.slave  bus
);
    localparam int CW = $clog2(STABLE_CNT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic rise;
    } evt_t;

    logic [1:0]       sync;
    logic             s;
    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             level_q, level_nxt;
    logic             post, post_rise;
    evt_t             evt_q;
    logic             pop, load, drop;
    logic             ovf_q;
    logic [CNT_W-1:0] edge_cnt_q;

    // Two-flop synchroniser; runs regardless of enable so s is always fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b00;
        else        sync <= {sync[0], bus.signal};
    end

    assign s = sync[1];

    // FSM state, stability counter and confirmed level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE_LOW;
            cnt     <= '0;
            level_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            level_q <= level_nxt;
        end
    end

    // Next state: a check starts on the first differing sample (cnt=1) and
    // confirms on the STABLE_CNT-th; any disagreeing sample or enable=0
    // drops back to the idle state of the current level.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level_q;
        post      = 1'b0;
        post_rise = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (s && bus.enable) begin
                    state_nxt = CHECK_HIGH;
                    cnt_nxt   = CW'(1);
                end
            end
            CHECK_HIGH: begin
                if (!bus.enable || !s) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    post      = 1'b1;
                    post_rise = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!s && bus.enable) begin
                    state_nxt = CHECK_LOW;
                    cnt_nxt   = CW'(1);
                end
            end
            CHECK_LOW: begin
                if (!bus.enable || s) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    post      = 1'b1;
                    post_rise = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pop happens first, so a post in the same cycle as an accept lands
    // in the freed slot without a bubble.
    assign pop  = evt_q.valid & bus.evt_ready;
    assign load = post & (~evt_q.valid | pop);
    assign drop = post & ~load;

    // One-entry event buffer; contents held until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q <= '0;
        end else if (load) begin
            evt_q.valid <= 1'b1;
            evt_q.rise  <= post_rise;
        end else if (pop) begin
            evt_q.valid <= 1'b0;
        end
    end

    // Edge counter counts every confirmed edge (buffered or dropped) and
    // wraps; clear takes effect before a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         edge_cnt_q <= '0;
        else if (bus.clear) edge_cnt_q <= CNT_W'(post);
        else if (post)      edge_cnt_q <= edge_cnt_q + 1'b1;
    end

    // Sticky drop flag; a same-cycle drop wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ovf_q <= 1'b0;
        else if (drop)      ovf_q <= 1'b1;
        else if (bus.clear) ovf_q <= 1'b0;
    end

    assign bus.level      = level_q;
    assign bus.evt_valid  = evt_q.valid;
    assign bus.evt_rise   = evt_q.rise;
    assign bus.edge_count = edge_cnt_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_signal_debounce_ctrl.sv
// Bench for signal_debounce_ctrl: directed vector table, hand-written
// corner sequences and randomized stimulus against a run-length model.
module tb_signal_debounce_ctrl;
    localparam int STABLE_CNT = 4;
    localparam int CNT_W      = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #2 clk = ~clk;

    signal_debounce_ctrl_if #(.CNT_W(CNT_W)) bus();

    signal_debounce_ctrl #(.STABLE_CNT(STABLE_CNT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {level, valid, rise, overflow, edge_count}
    function automatic logic [31:0] pk(input logic l, input logic v, input logic r,
                                       input logic o, input logic [7:0] c);
        return {20'd0, l, v, r, o, c};
    endfunction

    function automatic logic [31:0] dut_out();
        return pk(bus.level, bus.evt_valid, bus.evt_rise, bus.overflow, bus.edge_count);
    endfunction

    // Reference model: s is the input delayed by two samples; the level flips
    // once STABLE_CNT consecutive enabled samples disagree with it.
    bit [1:0]         m_sync;
    bit               m_level, m_valid, m_rise, m_ovf;
    int               m_run;
    logic [CNT_W-1:0] m_cnt;
    bit               mon_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sync = 2'b00; m_level = 0; m_valid = 0; m_rise = 0;
            m_ovf = 0; m_run = 0; m_cnt = '0;
        end else begin
            bit s, post, prise, popped;
            s = m_sync[1];
            post = 0; prise = 0;
            popped = m_valid && bus.evt_ready;
            if (bus.enable && s != m_level) begin
                m_run++;
                if (m_run == STABLE_CNT) begin
                    m_level = s; m_run = 0; post = 1; prise = s;
                end
            end else begin
                m_run = 0;
            end
            if (popped) m_valid = 0;
            if (bus.clear) begin m_cnt = '0; m_ovf = 0; end
            if (post) begin
                m_cnt = m_cnt + 1'b1;
                if (!m_valid) begin m_valid = 1; m_rise = prise; end
                else m_ovf = 1;
            end
            m_sync = {m_sync[0], bus.signal};
        end
    end

    always @(negedge clk) begin
        if (rst_n && mon_en)
            chk("model", dut_out(), pk(m_level, m_valid, m_rise, m_ovf, m_cnt));
    end

    typedef struct {
        bit sig, en, clr, rdy;
        int n;
        bit lvl, vld, rise, ovf;
        int cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sig, input bit en, input bit clr, input bit rdy);
        bus.signal = sig; bus.enable = en; bus.clear = clr; bus.evt_ready = rdy;
    endtask

    initial begin
        drive(0, 1, 0, 1);
        tick(1);
        chk("reset", dut_out(), pk(0, 0, 0, 0, 8'd0));
        tick(2);
        rst_n = 1'b1;
        mon_en = 1'b1;

        //            sig en clr rdy n  lvl vld rise ovf cnt
        tbl.push_back('{1, 1, 0, 1, 5, 0, 0, 0, 0, 0});  // rise: not yet at edge k+4
        tbl.push_back('{1, 1, 0, 1, 1, 1, 1, 1, 0, 1});  // confirmed at edge k+5
        tbl.push_back('{1, 1, 0, 1, 1, 1, 0, 1, 0, 1});  // accepted
        tbl.push_back('{0, 1, 0, 1, 5, 1, 0, 1, 0, 1});
        tbl.push_back('{0, 1, 0, 1, 1, 0, 1, 0, 0, 2});  // fall confirmed
        tbl.push_back('{0, 1, 0, 1, 1, 0, 0, 0, 0, 2});
        tbl.push_back('{1, 1, 0, 1, 2, 0, 0, 0, 0, 2});  // 2-cycle glitch
        tbl.push_back('{0, 1, 0, 1, 8, 0, 0, 0, 0, 2});  // rejected
        tbl.push_back('{1, 1, 0, 0, 6, 1, 1, 1, 0, 3});  // held, not ready
        tbl.push_back('{0, 1, 0, 0, 6, 0, 1, 1, 1, 4});  // second edge dropped
        tbl.push_back('{0, 1, 0, 1, 1, 0, 0, 1, 1, 4});  // drained
        tbl.push_back('{0, 1, 1, 1, 1, 0, 0, 1, 0, 0});  // clear
        tbl.push_back('{0, 1, 0, 1, 1, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 4, 0, 0, 1, 0, 0});  // mid-check, cnt=2
        tbl.push_back('{1, 0, 0, 1, 3, 0, 0, 1, 0, 0});  // enable=0 aborts
        tbl.push_back('{1, 1, 0, 1, 3, 0, 0, 1, 0, 0});  // restart
        tbl.push_back('{1, 1, 0, 1, 1, 1, 1, 1, 0, 1});  // 4 cycles after re-enable
        tbl.push_back('{1, 1, 0, 1, 1, 1, 0, 1, 0, 1});
        tbl.push_back('{0, 1, 0, 1, 5, 1, 0, 1, 0, 1});
        tbl.push_back('{0, 1, 1, 1, 1, 0, 1, 0, 0, 1});  // clear + edge -> 1
        tbl.push_back('{0, 1, 0, 1, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 6, 1, 1, 1, 0, 2});
        tbl.push_back('{0, 1, 0, 0, 5, 1, 1, 1, 0, 2});
        tbl.push_back('{0, 1, 1, 0, 1, 0, 1, 1, 1, 1});  // clear + drop -> ovf=1
        tbl.push_back('{0, 1, 0, 1, 1, 0, 0, 1, 1, 1});
        tbl.push_back('{0, 1, 1, 1, 1, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 6, 1, 1, 1, 0, 1});
        tbl.push_back('{0, 1, 0, 0, 5, 1, 1, 1, 0, 1});
        tbl.push_back('{0, 1, 0, 1, 1, 0, 1, 0, 0, 2});  // pop + load, no gap
        tbl.push_back('{0, 1, 0, 1, 1, 0, 0, 0, 0, 2});

        foreach (tbl[i]) begin
            drive(tbl[i].sig, tbl[i].en, tbl[i].clr, tbl[i].rdy);
            tick(tbl[i].n);
            chk($sformatf("vec%0d", i), dut_out(),
                pk(tbl[i].lvl, tbl[i].vld, tbl[i].rise, tbl[i].ovf, 8'(tbl[i].cnt)));
        end

        // Square wave, 30 ns halves, offset away from clock edges.
        drive(0, 1, 1, 1);
        tick(1);
        bus.clear = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            bus.signal = ~bus.signal;
            #30;
        end
        tick(10);
        chk("square", dut_out(), pk(0, 0, 0, 0, 8'd6));

        // Wrap of edge_count.
        drive(0, 1, 1, 1);
        tick(1);
        bus.clear = 1'b0;
        for (int i = 0; i < 255; i++) begin
            bus.signal = ~bus.signal;
            tick(6);
        end
        chk("wrap_pre", {24'd0, bus.edge_count}, 32'd255);
        bus.signal = ~bus.signal;
        tick(6);
        chk("wrap", {23'd0, bus.overflow, bus.edge_count}, 32'd0);

        // Reset mid-check with a pending event.
        drive(1, 1, 0, 0);
        tick(6);
        chk("pending", {31'd0, bus.evt_valid}, 32'd1);
        bus.signal = 1'b0;
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("async_rst", dut_out(), pk(0, 0, 0, 0, 8'd0));
        drive(1, 1, 0, 1);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("rst_sig1_early", dut_out(), pk(0, 0, 0, 0, 8'd0));
        tick(1);
        chk("rst_sig1_rise", dut_out(), pk(1, 1, 1, 0, 8'd1));

        // Randomized stimulus against the model.
        for (int seg = 0; seg < 500; seg++) begin
            int hold;
            bus.signal = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 9);
            for (int c = 0; c < hold; c++) begin
                bus.enable    = ($urandom_range(0, 9) != 0);
                bus.evt_ready = 1'($urandom_range(0, 1));
                bus.clear     = ($urandom_range(0, 29) == 0);
                tick(1);
            end
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/signal_debounce_ctrl.md
Name: signal_debounce_ctrl

Overview:
Controller that sequences a 2-stage input shift register (synchroniser) for a single asynchronous `signal`.
- Filters glitches by requiring a stable level for STABLE_CNT synchronised samples.
- Emits confirmed rise/fall events through a one-entry valid/ready buffer.
- Keeps a confirmed-edge counter.
- Sits between raw board/testbench stimulus and downstream logic that must see clean, one-per-transition events.

Parameters:
STABLE_CNT, 4, consecutive equal synchronised samples needed to confirm a transition (legal range >= 2)
CNT_W, 8, width of edge_count

Ports:
clk  input  1  single system clock, rising-edge active
rst_n  input  1  reset, asynchronous, active-low
signal  input  1  raw asynchronous input
enable  input  1  1 = filtering/events active; 0 = hold confirmed level, abort checks
clear  input  1  synchronous clear of edge_count and overflow
evt_ready  input  1  consumer accepts event when evt_valid=1
evt_valid  output  1  event buffer holds an event
evt_rise  output  1  event type: 1 = rising, 0 = falling (valid when evt_valid=1)
level  output  1  debounced confirmed level
edge_count  output  CNT_W  number of confirmed edges, mod 2^CNT_W
overflow  output  1  sticky: an event was dropped

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous assert, active-low.
- Reset values: sync[1:0]=00, FSM=IDLE_LOW, level=0, evt_valid=0, evt_rise=0, edge_count=0, overflow=0, stability counter=0.
- Synchroniser runs every cycle, including when enable=0: sync[0]<=signal, sync[1]<=sync[0]. The FSM uses only sync[1] ("s").
- FSM states: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW. Counter width is clog2(STABLE_CNT)+1.
  - IDLE_LOW: s=1 and enable=1 -> CHECK_HIGH, cnt=1; otherwise stay.
  - CHECK_HIGH:
    - enable=0 or s=0 -> IDLE_LOW, cnt=0 (glitch rejected, no event).
    - cnt==STABLE_CNT-1 -> IDLE_HIGH, level<=1, post rise event, cnt=0.
    - Otherwise cnt++.
  - IDLE_HIGH / CHECK_LOW: mirror of the above with polarity inverted; confirmation sets level<=0 and posts a fall event.
- Latency: signal changes before edge k and stays stable. level changes on edge k+STABLE_CNT+1, i.e. after STABLE_CNT samples of s. Example: edge k+5 for the default STABLE_CNT=4.
- Event buffer, evaluated each cycle in this order:
  - Pop if evt_valid&evt_ready.
  - Then, on a post:
    - If the buffer is empty after the pop: load, evt_valid=1, evt_rise=type.
    - Otherwise drop the event and set overflow=1.
  - Consequences: simultaneous pop+post loads the new event with no gap; a post while full and not ready is dropped.
  - evt_valid/evt_rise stay stable until accepted.
- edge_count: +1 on every confirmed edge, whether buffered or dropped. Wraps from 2^CNT_W-1 to 0; no saturation, and wrap does not set overflow.
- clear: zeroes edge_count and overflow. Does not touch FSM, level or the buffer. clear and confirmed edge in the same cycle -> edge_count=1. clear and drop in the same cycle -> overflow=1.
- enable=0: no new events; any in-progress check aborts to its IDLE state; the buffer still drains via evt_ready. On enable rising with s≠level, a normal check starts from the next cycle.
- Reset mid-check or with a pending event: everything returns to reset values immediately; the pending event is lost; no overflow is set.
- Reset released with signal=1 -> rise confirmed after the normal latency, counted from the first sampling edge.

Test Plan:
1. Reset, signal=0, enable=1, evt_ready=1; raise signal and hold 40 cycles -> level=1 exactly 5 edges after first sample; one evt_valid pulse with evt_rise=1; edge_count=1.
2. Glitch: signal high for 2 cycles then low -> level stays 0, evt_valid never asserts, edge_count=0.
3. Square wave, 30 ns halves (clk period 4 ns), evt_ready=1, 6 transitions -> level follows with 5-cycle lag; events alternate rise/fall; edge_count=6; overflow=0.
4. evt_ready=0, two confirmed edges -> first event held (evt_rise=1), second dropped, overflow=1, edge_count=2. Then evt_ready=1 for one cycle -> evt_valid=0. Then clear -> overflow=0, edge_count=0.
5. enable=0 mid-check (cnt=2) -> no level change or event. enable=1 with signal still high -> rise confirmed 4 cycles later.
6. Preload edge_count to 255 (CNT_W=8) via 255 edges, then one more edge -> edge_count=0, overflow=0. Then rst_n low mid-check with pending event -> all outputs at reset values asynchronously.
